pss_generator: RTL and testbench
================================

Name: pss_generator

Overview:
- Transmit-side counterpart of the PSS correlator.
- On a start request, generates the 127-symbol NR PSS sequence d(n) for a given N_id_2 (TS 38.211 7.4.2.2) as BPSK complex samples.
- Streams the samples over an AXI-stream master.
- Sits ahead of the IFFT/SSB mapper in the transmit chain. The bench also uses it as a golden stimulus source for the correlator.

Parameters:
- OUT_DW, 32, total output width; re in [OUT_DW/2-1:0], im in [OUT_DW-1:OUT_DW/2], both signed.
- AMP, 16'sd8192, signed magnitude emitted for d(n)=+1; -AMP is emitted for -1. Must fit in OUT_DW/2 bits.
- FFT_LEN, 256, output frame length; used only with PSS_GEN_SC_MAP_EN. Must be >= 128.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- start_i  in  1  start request pulse
- N_id_2_i  in  2  sector id 0..2, sampled when start_i is accepted
- m_axis_out_tdata  out  OUT_DW  {im, re} sample
- m_axis_out_tvalid  out  1  sample valid
- m_axis_out_tready  in  1  downstream ready
- m_axis_out_tlast  out  1  last sample of the frame
- busy_o  out  1  high in any state other than IDLE

Behaviour:
- Interface (already decided): one clock clk_i; reset_i is synchronous and active-high.
- Reset: state=IDLE; tdata=0, tvalid=0, tlast=0, busy_o=0. Reset mid-frame aborts the frame immediately, with no tlast.
- LFSR: 7-bit register holding x(i)..x(i+6).
  - Init on accept: x(6..0)=1110110, i.e. x(0)=0, x(1)=1, x(2)=1, x(3)=0, x(4)=1, x(5)=1, x(6)=1.
  - Step: shift; new x(i+7) = x(i+4) XOR x(i).
  - Output bit is x(i); d = 1 - 2*x(i).
- States:
  - IDLE:
    - start_i=1 and N_id_2_i<=2 → load LFSR, load skip counter = 43*N_id_2, go to SKIP.
    - N_id_2_i=3 → start ignored, stay IDLE.
    - start_i in any state other than IDLE is ignored.
  - SKIP: one LFSR step per cycle and decrement the counter; at counter=0 go to RUN. A zero count leaves SKIP on the next cycle.
  - RUN:
    - tvalid=1; tdata = {0, d>0 ? AMP : -AMP}.
    - Sample counter n=0..126.
    - The LFSR steps and n increments only on a tvalid&&tready handshake.
    - tdata, tvalid and tlast stay stable while tready=0.
    - tlast=1 when n=126; the handshake with tlast returns to IDLE and tvalid drops the next cycle.
- Latency: start accept → first tvalid = 43*N_id_2 + 2 cycles (0 → 2, 1 → 45, 2 → 88).
- Output registered; throughput 1 sample/cycle with tready held high.
- Back-to-back: a start_i in the same cycle as the tlast handshake is ignored, because the FSM is not yet in IDLE. The earliest accepted restart is one cycle later.

Optional Feature:
- Macro: PSS_GEN_SC_MAP_EN.
- Defined: the frame is FFT_LEN samples in natural FFT bin order, with the PSS centred on DC.
  - Bin k=0..63 carries d(63..126).
  - Bins 64..FFT_LEN-64 carry 0+j0.
  - Bins FFT_LEN-63..FFT_LEN-1 carry d(0..62).
  - SKIP count becomes 43*N_id_2+63.
  - The LFSR pauses during zero bins and continues with d(127)=d(0) by periodicity, so no reload is needed.
  - tlast is asserted at bin FFT_LEN-1.
- Undefined: the 127-sample frame described in Behaviour; FFT_LEN is unused.

Decomposition:
- Shared package pss_pkg holds:
  - PSS_LEN=127, PSS_LFSR_INIT=7'b1110110, PSS_NID2_SHIFT=43;
  - state enum {IDLE, SKIP, RUN};
  - the IQ packing helper, shared with the correlator bench.
- Sub-module: pss_lfsr (init, step enable, output bit). The FSM and AXI logic stay in pss_generator.

Test Plan:
- N_id_2=0, AMP=1000, tready=1 → first tvalid 2 cycles after start.
  - re = +1000, -1000, -1000, +1000, -1000, -1000, -1000, -1000 (d(7), x(7)=1).
  - im=0 throughout; exactly 127 samples; tlast only on the 127th.
- N_id_2=1 and 2 → first tvalid at cycles 45 / 88. Full sequence equals the N_id_2=0 sequence cyclically shifted by 43 / 86 (golden model compare).
- Random tready (50%) → sample sequence identical to tready=1; tdata stable whenever tvalid&&!tready; total handshakes = 127.
- start_i pulsed during RUN, and start with N_id_2=3 in IDLE → no effect; busy_o stays 0 for the invalid id.
- reset_i asserted at sample 60 → next cycle tvalid=0, busy_o=0; a new start then produces a full correct frame from d(0).
- With PSS_GEN_SC_MAP_EN, FFT_LEN=256, N_id_2=0:
  - bin0 = d(63), bin63 = d(126), bins 64..192 = 0, bin193 = d(0) = +AMP, bin255 = d(62);
  - tlast at bin 255;
  - the frame fed to a 256-point IFFT and then the correlator peaks at one index.

Source files
------------

// File: rtl/pss_pkg.sv
// Shared constants, FSM state type and IQ packing helper for the PSS generator.
// The packing helper is also used by the correlator bench.
package pss_pkg;

    localparam int PSS_LEN = 127;
    localparam logic [6:0] PSS_LFSR_INIT = 7'b1110110;
    localparam int PSS_NID2_SHIFT = 43;

    typedef enum logic [1:0] {
        IDLE,
        SKIP,
        RUN
    } pss_state_t;

    // Packs {im, re}, each hw bits wide, into the low 2*hw bits.
    function automatic logic [63:0] pss_pack_iq(
        input logic signed [31:0] re,
        input logic signed [31:0] im,
        input int unsigned hw
    );
        logic [63:0] m;
        m = (64'd1 << hw) - 64'd1;
        return (64'(re) & m) | ((64'(im) & m) << hw);
    endfunction

endpackage

// File: rtl/pss_generator_if.sv
// AXI-stream style sample channel between the PSS generator and its sink.
interface pss_generator_if #(
    parameter int DW = 32
);

    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );

endinterface

// File: rtl/pss_lfsr.sv
// 7-bit m-sequence register for the NR PSS: x(i+7) = x(i+4) ^ x(i).
// Bit j of the register holds x(i+j); the output bit is x(i).
module pss_lfsr
    import pss_pkg::*;
(
    input  logic clk_i,
    input  logic reset_i,
    input  logic init_i,
    input  logic step_i,
    output logic bit_o
);

    logic [6:0] x_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            x_q <= '0;
        end else if (init_i) begin
            x_q <= PSS_LFSR_INIT;
        end else if (step_i) begin
            x_q <= {x_q[4] ^ x_q[0], x_q[6:1]};
        end
    end

    assign bit_o = x_q[0];

endmodule

// File: rtl/pss_generator.sv
// NR PSS d(n) generator streaming BPSK samples over an AXI-stream master.
// Define PSS_GEN_SC_MAP_EN to emit an FFT_LEN frame with the PSS centred on DC.
module pss_generator
    import pss_pkg::*;
#(
    parameter int        OUT_DW  = 32,
    parameter int signed AMP     = 8192,
    parameter int        FFT_LEN = 256
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic [1:0]      N_id_2_i,
    pss_generator_if.master m_axis_out,
    output logic            busy_o
);

    localparam int unsigned HW = OUT_DW / 2;
`ifdef PSS_GEN_SC_MAP_EN
    localparam int FRAME    = FFT_LEN;
    localparam int SKIP_OFS = 63;
`else
    localparam int FRAME    = PSS_LEN;
    localparam int SKIP_OFS = 0;
`endif
    // One counter serves as skip count and as bin/sample index.
    localparam int CW = $clog2(FFT_LEN + 150);

    pss_state_t        state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic [OUT_DW-1:0] tdata_q;
    logic              tvalid_q;
    logic              tlast_q;

    logic              accept;
    logic              load;
    logic              lfsr_step;
    logic              lfsr_bit;
    logic              pss_bin;
    logic              last_bin;
    logic signed [31:0] re_val;
    logic [OUT_DW-1:0] sample;

    pss_lfsr u_lfsr (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .init_i  (accept),
        .step_i  (lfsr_step),
        .bit_o   (lfsr_bit)
    );

`ifdef PSS_GEN_SC_MAP_EN
    assign pss_bin = (cnt_q < CW'(64)) || (cnt_q > CW'(FFT_LEN - 64));
`else
    assign pss_bin = 1'b1;
`endif

    assign last_bin = (cnt_q == CW'(FRAME - 1));
    assign re_val   = !pss_bin ? 32'sd0 : (lfsr_bit ? -AMP : AMP);
    assign sample   = OUT_DW'(pss_pack_iq(re_val, 32'sd0, HW));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        load      = 1'b0;
        lfsr_step = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i && N_id_2_i != 2'd3) begin
                    accept  = 1'b1;
                    state_d = SKIP;
                end
            end
            SKIP: begin
                if (cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    lfsr_step = 1'b1;
                end
            end
            RUN: begin
                // Refill the output register unless the tlast sample is parked.
                load = !(tvalid_q && tlast_q)
                    && (!tvalid_q || m_axis_out.tready);
                lfsr_step = load && pss_bin;
                if (tvalid_q && tlast_q && m_axis_out.tready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else begin
            if (accept) begin
                cnt_q <= CW'(PSS_NID2_SHIFT * int'(N_id_2_i) + SKIP_OFS);
            end else if (state_q == SKIP && cnt_q != '0) begin
                cnt_q <= cnt_q - CW'(1);
            end else if (load) begin
                cnt_q <= cnt_q + CW'(1);
            end

            if (load) begin
                tdata_q  <= sample;
                tvalid_q <= 1'b1;
                tlast_q  <= last_bin;
            end else if (tvalid_q && m_axis_out.tready) begin
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
            end
        end
    end

    assign m_axis_out.tdata  = tdata_q;
    assign m_axis_out.tvalid = tvalid_q;
    assign m_axis_out.tlast  = tlast_q;
    assign busy_o            = (state_q != IDLE);

endmodule

// File: tb/tb_pss_generator.sv
// Self-checking bench for pss_generator: table of frame scenarios plus
// hand-written reset, invalid-id and back-to-back sequences.
module tb_pss_generator;

    localparam int OUT_DW  = 32;
    localparam int AMP     = 1000;
    localparam int FFT_LEN = 256;
`ifdef PSS_GEN_SC_MAP_EN
    localparam int FL   = FFT_LEN;
    localparam int SOFS = 63;
`else
    localparam int FL   = 127;
    localparam int SOFS = 0;
`endif

    logic       clk = 1'b0;
    logic       reset_i;
    logic       start_i;
    logic [1:0] nid;
    logic       busy;

    pss_generator_if #(.DW(OUT_DW)) axis ();

    pss_generator #(
        .OUT_DW  (OUT_DW),
        .AMP     (AMP),
        .FFT_LEN (FFT_LEN)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .start_i    (start_i),
        .N_id_2_i   (nid),
        .m_axis_out (axis),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] nid;
        bit         rnd;
        bit         mid_start;
        bit         b2b;
        int         rst_at;
    } vec_t;

    vec_t        vecs [9];
    int          checks = 0;
    int          errors = 0;
    logic        xs [0:133];
    int          dre [0:126];
    logic [31:0] cap [0:FFT_LEN-1];
    int          first8 [8];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int exp_re(input int n, input int id);
`ifdef PSS_GEN_SC_MAP_EN
        if (n < 64) return dre[(63 + n + 43 * id) % 127];
        if (n <= FFT_LEN - 64) return 0;
        return dre[(n - (FFT_LEN - 63) + 43 * id) % 127];
`else
        return dre[(n + 43 * id) % 127];
`endif
    endfunction

    task automatic run_frame(input int vi);
        vec_t        v;
        string       tag;
        int          lat, hs, stab_err, tlast_bad, guard, eid;
        logic [31:0] prev_d;
        logic        prev_l;
        bit          prev_stall;
        v   = vecs[vi];
        tag = $sformatf("v%0d", vi);
        axis.tready = 1'b1;
        nid = v.nid;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        nid = 2'd0;
        lat = 0;
        while (!axis.tvalid && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        eid = int'(v.nid);
        chk({tag, "_latency"}, 64'(lat), 64'(43 * eid + 2 + SOFS));
        hs = 0; stab_err = 0; tlast_bad = 0; guard = 0;
        prev_stall = 1'b0; prev_d = '0; prev_l = 1'b0;
        while (guard < 5000) begin
            axis.tready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (prev_stall && (!axis.tvalid || axis.tdata !== prev_d
                               || axis.tlast !== prev_l))
                stab_err++;
            prev_stall = axis.tvalid && !axis.tready;
            prev_d = axis.tdata;
            prev_l = axis.tlast;
            start_i = v.mid_start && hs == 30;
            nid = start_i ? 2'd2 : 2'd0;
            if (v.rst_at >= 0 && hs == v.rst_at) begin
                reset_i = 1'b1;
                @(negedge clk);
                reset_i = 1'b0;
                chk({tag, "_rst_tvalid"}, 64'(axis.tvalid), 64'(0));
                chk({tag, "_rst_tlast"}, 64'(axis.tlast), 64'(0));
                chk({tag, "_rst_busy"}, 64'(busy), 64'(0));
                return;
            end
            if (axis.tvalid && axis.tready) begin
                if (hs < FFT_LEN) cap[hs] = axis.tdata;
                if (axis.tlast !== (hs == FL - 1)) tlast_bad++;
                hs++;
                if (axis.tlast) begin
                    start_i = v.b2b;
                    @(negedge clk);
                    start_i = 1'b0;
                    break;
                end
            end
            @(negedge clk);
            guard++;
        end
        chk({tag, "_handshakes"}, 64'(hs), 64'(FL));
        chk({tag, "_tlast_pos"}, 64'(tlast_bad), 64'(0));
        chk({tag, "_stable"}, 64'(stab_err), 64'(0));
        chk({tag, "_end_tvalid"}, 64'(axis.tvalid), 64'(0));
        chk({tag, "_end_busy"}, 64'(busy), 64'(0));
        if (hs == FL) begin
            for (int i = 0; i < FL; i++) begin
                chk($sformatf("%s_s%0d", tag, i), 64'(cap[i]),
                    64'({16'h0, 16'(exp_re(i, eid))}));
            end
        end
    endtask

    initial begin
        logic [6:0] ini;
        ini = 7'b1110110;
        for (int i = 0; i < 7; i++) xs[i] = ini[i];
        for (int i = 0; i < 127; i++) begin
            xs[i + 7] = xs[i + 4] ^ xs[i];
            dre[i] = xs[i] ? -AMP : AMP;
        end
        first8 = '{1000, -1000, -1000, 1000, -1000, -1000, -1000, -1000};

        //          nid   rnd   mid   b2b   rst_at
        vecs[0] = '{2'd0, 1'b0, 1'b0, 1'b0, -1};
        vecs[1] = '{2'd1, 1'b0, 1'b0, 1'b0, -1};
        vecs[2] = '{2'd2, 1'b0, 1'b0, 1'b0, -1};
        vecs[3] = '{2'd0, 1'b1, 1'b0, 1'b0, -1};
        vecs[4] = '{2'd2, 1'b1, 1'b1, 1'b0, -1};
        vecs[5] = '{2'd1, 1'b0, 1'b0, 1'b1, -1};
        vecs[6] = '{2'd0, 1'b0, 1'b0, 1'b0, -1};
        vecs[7] = '{2'd0, 1'b0, 1'b0, 1'b0, 60};
        vecs[8] = '{2'd0, 1'b0, 1'b0, 1'b0, -1};

        reset_i = 1'b1;
        start_i = 1'b0;
        nid = 2'd0;
        axis.tready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_tvalid", 64'(axis.tvalid), 64'(0));
        chk("reset_tlast", 64'(axis.tlast), 64'(0));
        chk("reset_tdata", 64'(axis.tdata), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        reset_i = 1'b0;
        @(negedge clk);

        nid = 2'd3;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        nid = 2'd0;
        repeat (3) begin
            chk("nid3_busy", 64'(busy), 64'(0));
            chk("nid3_tvalid", 64'(axis.tvalid), 64'(0));
            @(negedge clk);
        end

        for (int i = 0; i < 9; i++) begin
            run_frame(i);
            if (i == 0) begin
`ifdef PSS_GEN_SC_MAP_EN
                chk("bin193", 64'(cap[193]), 64'({16'h0, 16'(AMP)}));
                chk("bin64", 64'(cap[64]), 64'(0));
                chk("bin128", 64'(cap[128]), 64'(0));
                chk("bin192", 64'(cap[192]), 64'(0));
`else
                for (int k = 0; k < 8; k++) begin
                    chk($sformatf("first8_%0d", k), 64'(cap[k]),
                        64'({16'h0, 16'(first8[k])}));
                end
`endif
            end
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
